// File: rtl/sram_march_bist.sv
// rtl/sram_march_bist.sv - March C- BIST engine for a single-port SRAM macro with 1-cycle read latency
// Optional feature macro: SRAM_BIST_FAIL_COUNT_EN (adds 16-bit saturating fail_count output)
module sram_march_bist #(
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 32,
  parameter int WMASK_WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  pattern,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic [2:0]             fail_elem,
  output logic [ADDR_WIDTH-1:0]  fail_addr,
  output logic [DATA_WIDTH-1:0]  fail_data,
  output logic [DATA_WIDTH-1:0]  fail_expected,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
`ifdef SRAM_BIST_FAIL_COUNT_EN
  ,
  output logic [15:0]            fail_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Elements 1..4 are (read, write) pairs; 0 is a lone write, 5 a lone read.
  function automatic logic op_is_write(input logic [2:0] e, input logic p);
    return (e == 3'd0) || ((e != 3'd5) && p);
  endfunction

  // Logical value ("0" = background, "1" = inverted background) of the op.
  function automatic logic op_value(input logic [2:0] e, input logic p);
    logic v;
    v = 1'b0;
    case (e)
      3'd1, 3'd3: v = p;
      3'd2, 3'd4: v = ~p;
      default:    v = 1'b0;
    endcase
    return v;
  endfunction

  function automatic logic elem_is_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   pat_q, pat_d;

  // Position of the op currently presented on the SRAM port.
  logic [2:0]              pos_elem_q, pos_elem_d;
  logic [ADDR_WIDTH-1:0]   pos_addr_q, pos_addr_d;
  logic                    pos_phase_q, pos_phase_d;

  logic [2:0]              nxt_elem;
  logic [ADDR_WIDTH-1:0]   nxt_addr;
  logic                    nxt_phase;
  logic                    last_phase;
  logic                    addr_end;
  logic                    last_op;

  logic                    sram_we_q, sram_we_d;
  logic [WMASK_WIDTH-1:0]  sram_wmask_q, sram_wmask_d;
  logic [ADDR_WIDTH-1:0]   sram_addr_q, sram_addr_d;
  logic [DATA_WIDTH-1:0]   sram_din_q, sram_din_d;
  logic [DATA_WIDTH-1:0]   bg;

  // Read-check pipeline: describes the read the macro sampled at the last edge.
  logic                    chk_valid_q, chk_valid_d;
  logic [DATA_WIDTH-1:0]   exp_q, exp_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2:0]              elem_q, elem_d;
  logic                    miscompare;

  logic                    fail_q;
  logic [2:0]              fail_elem_q;
  logic [ADDR_WIDTH-1:0]   fail_addr_q;
  logic [DATA_WIDTH-1:0]   fail_data_q;
  logic [DATA_WIDTH-1:0]   fail_expected_q;

  logic                    start_acc;

  assign start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (last_op) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  if (start) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_RUN, ST_FLUSH: busy = 1'b1;
      ST_DONE:          done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // March position stepping: finish the element's ops at one address, then move the address;
  // at the element's last address, advance the element and reload the start address.
  always_comb begin
    last_phase = ((pos_elem_q == 3'd0) || (pos_elem_q == 3'd5)) ? 1'b1 : pos_phase_q;
    addr_end   = elem_is_down(pos_elem_q) ? (pos_addr_q == '0) : (pos_addr_q == ADDR_MAX);
    last_op    = (pos_elem_q == 3'd5) && addr_end && last_phase;
    nxt_elem   = pos_elem_q;
    nxt_addr   = pos_addr_q;
    nxt_phase  = 1'b0;
    if (!last_phase) begin
      nxt_phase = 1'b1;
    end else if (addr_end) begin
      nxt_elem = pos_elem_q + 3'd1;
      nxt_addr = elem_is_down(nxt_elem) ? ADDR_MAX : '0;
    end else if (elem_is_down(pos_elem_q)) begin
      nxt_addr = pos_addr_q - ADDR_ONE;
    end else begin
      nxt_addr = pos_addr_q + ADDR_ONE;
    end
  end

  // Next position, pattern latch and next SRAM drive values
  always_comb begin
    pos_elem_d  = pos_elem_q;
    pos_addr_d  = pos_addr_q;
    pos_phase_d = pos_phase_q;
    pat_d       = pat_q;
    if (start_acc) begin
      pos_elem_d  = 3'd0;
      pos_addr_d  = '0;
      pos_phase_d = 1'b0;
      pat_d       = pattern;
    end else if ((state_q == ST_RUN) && !last_op) begin
      pos_elem_d  = nxt_elem;
      pos_addr_d  = nxt_addr;
      pos_phase_d = nxt_phase;
    end

    // The first op is loaded on the accept edge, before pat_q holds the new pattern.
    bg           = start_acc ? pattern : pat_q;
    sram_we_d    = 1'b0;
    sram_wmask_d = '0;
    sram_addr_d  = '0;
    sram_din_d   = '0;
    if (state_d == ST_RUN) begin
      sram_addr_d = pos_addr_d;
      if (op_is_write(pos_elem_d, pos_phase_d)) begin
        sram_we_d    = 1'b1;
        sram_wmask_d = '1;
        sram_din_d   = op_value(pos_elem_d, pos_phase_d) ? ~bg : bg;
      end
    end
  end

  // Read-check pipeline next values: capture the read being sampled by the macro this edge
  always_comb begin
    chk_valid_d = (state_q == ST_RUN) && !op_is_write(pos_elem_q, pos_phase_q);
    exp_d       = op_value(pos_elem_q, pos_phase_q) ? ~pat_q : pat_q;
    addr_d      = pos_addr_q;
    elem_d      = pos_elem_q;
  end

  assign miscompare = chk_valid_q && (sram_dout != exp_q);

  // Op position, pattern and registered SRAM port
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_elem_q   <= 3'd0;
      pos_addr_q   <= '0;
      pos_phase_q  <= 1'b0;
      pat_q        <= '0;
      sram_we_q    <= 1'b0;
      sram_wmask_q <= '0;
      sram_addr_q  <= '0;
      sram_din_q   <= '0;
    end else begin
      pos_elem_q   <= pos_elem_d;
      pos_addr_q   <= pos_addr_d;
      pos_phase_q  <= pos_phase_d;
      pat_q        <= pat_d;
      sram_we_q    <= sram_we_d;
      sram_wmask_q <= sram_wmask_d;
      sram_addr_q  <= sram_addr_d;
      sram_din_q   <= sram_din_d;
    end
  end

  // Read-check pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      chk_valid_q <= 1'b0;
      exp_q       <= '0;
      addr_q      <= '0;
      elem_q      <= 3'd0;
    end else begin
      chk_valid_q <= chk_valid_d;
      exp_q       <= exp_d;
      addr_q      <= addr_d;
      elem_q      <= elem_d;
    end
  end

  // First-miscompare capture; later miscompares leave the record untouched
  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      fail_q          <= 1'b0;
      fail_elem_q     <= 3'd0;
      fail_addr_q     <= '0;
      fail_data_q     <= '0;
      fail_expected_q <= '0;
    end else if (miscompare && !fail_q) begin
      fail_q          <= 1'b1;
      fail_elem_q     <= elem_q;
      fail_addr_q     <= addr_q;
      fail_data_q     <= sram_dout;
      fail_expected_q <= exp_q;
    end
  end

`ifdef SRAM_BIST_FAIL_COUNT_EN
  logic [15:0] fail_count_q;

  // Saturating count of every miscompared word
  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      fail_count_q <= 16'd0;
    end else if (miscompare && (fail_count_q != 16'hFFFF)) begin
      fail_count_q <= fail_count_q + 16'd1;
    end
  end

  assign fail_count = fail_count_q;
`endif

  assign fail          = fail_q;
  assign fail_elem     = fail_elem_q;
  assign fail_addr     = fail_addr_q;
  assign fail_data     = fail_data_q;
  assign fail_expected = fail_expected_q;
  assign sram_we       = sram_we_q;
  assign sram_wmask    = sram_wmask_q;
  assign sram_addr     = sram_addr_q;
  assign sram_din      = sram_din_q;

endmodule
